// File: rtl/debug_cmd_pkg.sv
// Shared constants and queue entry layout for the debug command path.
package debug_cmd_pkg;

  localparam int unsigned SR_W_DEF        = 38;
  localparam int unsigned IR_W_DEF        = 2;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned ACT_BIT_DEF     = 34;

  // One queued debug command: the instruction and the shift-register snapshot.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/debug_sync_edge.sv
// Synchronises one TCK-domain level into clk and emits a single-cycle strobe
// per rising edge. The detector only arms once the chain has been refilled
// after reset and has delivered a real low sample, so a level that was
// already high across reset never produces a strobe.
module debug_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic strobe_c
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              armed_q;
  logic              prev_q;
  logic              sync_out;

  assign sync_out = sync_q[STAGES-1];

  // Synchroniser chain, fill tracker, arm flag and previous-sample flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      if (fill_q[STAGES-1] && !sync_out) begin
        armed_q <= 1'b1;
      end
      prev_q <= sync_out;
    end
  end

  assign strobe_c = armed_q & sync_out & ~prev_q;

endmodule

// File: rtl/debug_cmd_sync_queue.sv
// Captures virtual-JTAG update-DR commands into a small in-order queue in the
// clk domain and reports update-IR events as single-cycle pulses.
// The entry layout comes from debug_cmd_pkg, so IR_W/SR_W are expected to
// match the package defaults.
module debug_cmd_sync_queue
  import debug_cmd_pkg::*;
#(
  parameter int unsigned SR_W        = SR_W_DEF,
  parameter int unsigned IR_W        = IR_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned ACT_BIT     = ACT_BIT_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [SR_W-1:0]              cmd_data,
  output logic                         cmd_action,
  output logic                         ir_update,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic             udr_strobe_c;
  logic             uir_strobe_c;

  cmd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             overflow_n;
  cmd_entry_t       new_c;
  cmd_entry_t       head_n;

  debug_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_udr),
    .strobe_c (udr_strobe_c)
  );

  debug_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_uir),
    .strobe_c (uir_strobe_c)
  );

  // Queue bookkeeping and next head; a push into the slot becoming head bypasses memory.
  always_comb begin
    new_c      = '0;
    new_c.ir   = IR_W_DEF'(ir_in);
    new_c.data = SR_W_DEF'(sr);
    full_c     = (count == CNT_W'(DEPTH));
    pop_c      = cmd_valid & cmd_ready;
    push_c     = udr_strobe_c & (~full_c | pop_c);
    drop_c     = udr_strobe_c & full_c & ~pop_c;
    wr_ptr_n   = wr_ptr_q;
    rd_ptr_n   = rd_ptr_q;
    count_n    = count;
    overflow_n = overflow;

    if (push_c) begin
      wr_ptr_n = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_n = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_n = count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_n = count - CNT_W'(1);
    end

    head_n = mem[rd_ptr_n];
    if (push_c && (wr_ptr_q == rd_ptr_n)) begin
      head_n = new_c;
    end
    if (count_n == '0) begin
      head_n = '0;
    end

    if (drop_c) begin
      overflow_n = 1'b1;
    end else if (ovf_clr) begin
      overflow_n = 1'b0;
    end
  end

  // Pointers, occupancy, registered head view, IR pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count      <= '0;
      cmd_valid  <= 1'b0;
      cmd_ir     <= '0;
      cmd_data   <= '0;
      cmd_action <= 1'b0;
      ir_update  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      count      <= count_n;
      cmd_valid  <= (count_n != '0);
      cmd_ir     <= IR_W'(head_n.ir);
      cmd_data   <= SR_W'(head_n.data);
      cmd_action <= head_n.data[ACT_BIT];
      ir_update  <= uir_strobe_c;
      overflow   <= overflow_n;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= new_c;
    end
  end

endmodule

// File: tb/tb_debug_cmd_sync_queue.sv
// Bench for debug_cmd_sync_queue: directed scenarios plus a long random run,
// all checked against a queue-level reference model and scoreboard.
module tb_debug_cmd_sync_queue;
  import debug_cmd_pkg::*;

  localparam int unsigned SR_W    = 38;
  localparam int unsigned IR_W    = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned ACT_BIT = 34;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             vs_udr;
  logic             vs_uir;
  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IR_W-1:0]  cmd_ir;
  logic [SR_W-1:0]  cmd_data;
  logic             cmd_action;
  logic             ir_update;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             ovf_clr;

  always #5 clk = ~clk;

  debug_cmd_sync_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ACT_BIT(ACT_BIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_action(cmd_action),
    .ir_update(ir_update), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted commands. A level rise seen by
  // the bench enters the queue SYNC+1 clock edges later if there is room.
  cmd_entry_t       exp_q[$];
  bit               m_ovf = 1'b0;
  bit               m_ir_upd = 1'b0;
  bit               prev_udr = 1'b1, prev_uir = 1'b1;
  bit               d1_udr, d2_udr, d1_uir, d2_uir;
  int               dut_pops = 0;
  logic [CNT_W-1:0] last_count = '0;
  logic             last_ovf = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0; m_ir_upd = 1'b0;
    prev_udr = 1'b1; prev_uir = 1'b1;
    d1_udr = 1'b0; d2_udr = 1'b0; d1_uir = 1'b0; d2_uir = 1'b0;
  endtask

  // Advances the model to the state after the coming rising edge.
  task automatic model_step();
    bit pop, fire_u, fire_i, set_ovf;
    cmd_entry_t e;
    pop     = (exp_q.size() != 0) && cmd_ready;
    fire_u  = d2_udr; d2_udr = d1_udr; d1_udr = vs_udr && !prev_udr; prev_udr = vs_udr;
    fire_i  = d2_uir; d2_uir = d1_uir; d1_uir = vs_uir && !prev_uir; prev_uir = vs_uir;
    m_ir_upd = fire_i;
    set_ovf = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (fire_u) begin
      if (exp_q.size() < DEPTH) begin
        e.ir = ir_in; e.data = sr;
        exp_q.push_back(e);
      end else begin
        set_ovf = 1'b1;
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) model_reset();
    check("cmd_valid", 64'(cmd_valid), 64'(exp_q.size() != 0));
    check("count", 64'(count), 64'(exp_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("ir_update", 64'(ir_update), 64'(m_ir_upd));
    if (cmd_valid && exp_q.size() != 0) begin
      check("head_ir", 64'(cmd_ir), 64'(exp_q[0].ir));
      check("head_data", 64'(cmd_data), 64'(exp_q[0].data));
      check("head_action", 64'(cmd_action), 64'(exp_q[0].data[ACT_BIT]));
    end
    if (overflow && !last_ovf) check("ovf_only_when_full", 64'(last_count), 64'(DEPTH));
    if (cmd_valid && cmd_ready) dut_pops++;
    last_count = count;
    last_ovf   = overflow;
    if (reset_n) model_step();
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                           input int hi, input int lo);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    tick(hi);
    vs_udr = 1'b0;
    tick(lo);
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return SR_W'(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, n_upd, udr_left, uir_left;
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_data", 64'(cmd_data), 64'd0);
    reset_n = 1'b1;
    tick(8);

    // Single command: latency, fields, then pop.
    ir_in = 2'b01; sr = 38'h04_0000_1234; vs_udr = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 3) vs_udr = 1'b0;
      if (cmd_valid) begin lat = k; break; end
    end
    vs_udr = 1'b0;
    check("t1_latency_in_3_4", 64'(lat >= 3 && lat <= 4), 64'd1);
    check("t1_cmd_ir", 64'(cmd_ir), 64'd1);
    check("t1_cmd_action", 64'(cmd_action), 64'd1);
    check("t1_cmd_data", 64'(cmd_data), 64'h04_0000_1234);
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    check("t1_count_after_pop", 64'(count), 64'd0);
    tick(4);

    // Five commands into a four-deep queue with no consumer.
    for (int i = 0; i < 5; i++) pulse_udr(IR_W'($urandom_range(0, 3)), rand_sr(), 3, 5);
    tick(4);
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_overflow_set", 64'(overflow), 64'd1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("t2_overflow_cleared", 64'(overflow), 64'd0);
    p0 = dut_pops;
    cmd_ready = 1'b1; tick(6); cmd_ready = 1'b0;
    check("t2_four_popped", 64'(dut_pops - p0), 64'd4);
    check("t2_empty", 64'(count), 64'd0);

    // Full queue with push and pop landing on the same edge.
    for (int i = 0; i < 4; i++) pulse_udr(IR_W'(i), rand_sr(), 3, 5);
    check("t3_count_full", 64'(count), 64'd4);
    ir_in = 2'b10; sr = rand_sr(); vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0; vs_udr = 1'b0;
    check("t3_count_stays", 64'(count), 64'd4);
    check("t3_no_overflow", 64'(overflow), 64'd0);
    tick(4);
    cmd_ready = 1'b1; tick(6); cmd_ready = 1'b0;

    // Update-IR pulse, then a very long update-DR level.
    vs_uir = 1'b1; tick(2); vs_uir = 1'b0;
    n_upd = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (ir_update) n_upd++;
    end
    check("t4_one_ir_update", 64'(n_upd), 64'd1);
    check("t4_count_unchanged", 64'(count), 64'd0);
    ir_in = 2'b11; sr = rand_sr(); vs_udr = 1'b1;
    tick(100); vs_udr = 1'b0; tick(6);
    check("t4_long_level_one_entry", 64'(count), 64'd1);
    cmd_ready = 1'b1; tick(3); cmd_ready = 1'b0;

    // Level held across reset release, then reset with entries pending.
    ir_in = 2'b01; sr = rand_sr(); vs_udr = 1'b1;
    tick(2);
    reset_n = 1'b0; tick(3); reset_n = 1'b1;
    tick(20);
    check("t5_no_entry_from_held_level", 64'(count), 64'd0);
    vs_udr = 1'b0; tick(8);
    for (int i = 0; i < 3; i++) pulse_udr(IR_W'(i + 1), rand_sr() | 38'h1, 3, 5);
    check("t5_three_entries", 64'(count), 64'd3);
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(cmd_valid), 64'd0);
    check("t5_async_count", 64'(count), 64'd0);
    check("t5_async_ir", 64'(cmd_ir), 64'd0);
    check("t5_async_data", 64'(cmd_data), 64'd0);
    check("t5_async_action", 64'(cmd_action), 64'd0);
    check("t5_async_overflow", 64'(overflow), 64'd0);
    check("t5_async_ir_update", 64'(ir_update), 64'd0);
    tick(2); reset_n = 1'b1; tick(8);

    // Random traffic with alternating light and heavy consumer load.
    udr_left = 1; uir_left = 7;
    for (int c = 0; c < 10000; c++) begin
      if (udr_left == 0) begin
        if (vs_udr) begin
          vs_udr = 1'b0; udr_left = int'($urandom_range(3, 6));
        end else begin
          vs_udr = 1'b1; ir_in = IR_W'($urandom_range(0, 3)); sr = rand_sr();
          udr_left = int'($urandom_range(1, 4));
        end
      end
      udr_left--;
      if (uir_left == 0) begin
        if (vs_uir) begin
          vs_uir = 1'b0; uir_left = int'($urandom_range(5, 20));
        end else begin
          vs_uir = 1'b1; uir_left = int'($urandom_range(1, 3));
        end
      end
      uir_left--;
      if (((c / 1000) % 2) == 1) cmd_ready = ($urandom_range(0, 7) == 0);
      else cmd_ready = ($urandom_range(0, 1) == 0);
      ovf_clr = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    vs_udr = 1'b0; vs_uir = 1'b0; ovf_clr = 1'b0;
    tick(6);
    cmd_ready = 1'b1; tick(8); cmd_ready = 1'b0;
    check("t6_drained", 64'(count), 64'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
